// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_arbiter: round-robin share of the data memory between core and debug. |
// | Optional DMEM_ARB_STATS_EN adds a saturating conflict counter.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ready,
  output logic [DATA_W-1:0] dbg_rdata,
`ifdef DMEM_ARB_STATS_EN
  output logic [CNT_W-1:0]  conflict_cnt,
`endif
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int       LAT_W       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic     c_OWN_CPU   = 1'b0;
  localparam logic     c_OWN_DBG   = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_owner;
  logic                r_last;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [LAT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic [DATA_W-1:0]   r_dbg_rdata;
  logic                w_any_req;
  logic                w_both_req;
  logic                w_grant;

  assign w_any_req  = cpu_req | dbg_req;
  assign w_both_req = cpu_req & dbg_req;
  // On conflict the port that did not win last time gets the memory.
  assign w_grant    = w_both_req ? ~r_last : dbg_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_next = S_ACCESS;
      S_ACCESS: if (r_cnt == '0) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner     <= c_OWN_CPU;
      r_last      <= c_OWN_DBG;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_grant;
            r_last  <= w_grant;
            r_we    <= w_grant ? dbg_we    : cpu_we;
            r_addr  <= w_grant ? dbg_addr  : cpu_addr;
            r_wdata <= w_grant ? dbg_wdata : cpu_wdata;
            r_cnt   <= LAT_W'(MEM_LAT - 1);
          end
        end
        S_ACCESS: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!r_we) begin
            if (r_owner == c_OWN_DBG) r_dbg_rdata <= mem_rdata;
            else                      r_cpu_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes decode from state so an asynchronous reset clears them at once.
  assign mem_read  = (r_state == S_ACCESS) & ~r_we;
  assign mem_write = (r_state == S_ACCESS) &  r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign cpu_ready = (r_state == S_RESP) & (r_owner == c_OWN_CPU);
  assign dbg_ready = (r_state == S_RESP) & (r_owner == c_OWN_DBG);
  assign cpu_rdata = r_cpu_rdata;
  assign dbg_rdata = r_dbg_rdata;
  assign cpu_stall = cpu_req & ~cpu_ready;

`ifdef DMEM_ARB_STATS_EN
  logic [CNT_W-1:0] r_conflict_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_conflict_cnt <= '0;
    end else if ((r_state == S_IDLE) && w_both_req && !(&r_conflict_cnt)) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule
`default_nettype wire
